ip_v4_header_check: RTL

IP_V4_HEADER_CHECK -- requirements
Module: ip_v4_header_check

---
 rtl/ip_v4_pkg.sv | 36 +++
 rtl/ip_v4_csum_add.sv | 22 ++
 rtl/ip_v4_header_check.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ip_v4_pkg.sv
// ---------------------------------------------------------------------------
// ip_v4_pkg
// Shared constants, types and the ones'-complement adder function used by the
// IPv4 header blocks (ip_v4_header_check, ip_v4_header_crc).
// No ports.
// ---------------------------------------------------------------------------
package ip_v4_pkg;

  localparam logic [3:0] IPV4_VERSION = 4'd4;
  localparam logic [3:0] IHL_MIN      = 4'd5;
  localparam logic [3:0] IHL_MAX      = 4'd15;

  // One 32-bit header word, big-endian field order.
  typedef logic [31:0] ip_v4_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2,
    SKIP = 2'd3
  } ip_v4_state_t;

  // acc + a + b in ones'-complement arithmetic.
  // The 18-bit raw sum is folded twice: the first fold can itself carry
  // (e.g. 1_FFFF -> FFFF + 1), the second fold never can.
  function automatic logic [15:0] ones_add3(input logic [15:0] acc,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    logic [17:0] raw;
    logic [16:0] fold1;
    raw   = {2'b00, acc} + {2'b00, a} + {2'b00, b};
    fold1 = {1'b0, raw[15:0]} + {15'd0, raw[17:16]};
    return fold1[15:0] + {15'd0, fold1[16]};
  endfunction

endpackage

// File: rtl/ip_v4_csum_add.sv
// ---------------------------------------------------------------------------
// ip_v4_csum_add
// Combinational ones'-complement accumulate of one 32-bit word, given as its
// two 16-bit halves, into a 16-bit accumulator with end-around carry.
// Ports:
//   acc  in  16  current accumulator
//   hi   in  16  upper half of the word
//   lo   in  16  lower half of the word
//   sum  out 16  folded result, never wider than 16 bits
// ---------------------------------------------------------------------------
module ip_v4_csum_add
  import ip_v4_pkg::*;
(
  input  logic [15:0] acc,
  input  logic [15:0] hi,
  input  logic [15:0] lo,
  output logic [15:0] sum
);

  assign sum = ones_add3(acc, hi, lo);

endmodule

// File: rtl/ip_v4_header_check.sv
// ---------------------------------------------------------------------------
// ip_v4_header_check
// Streams an IPv4 header one 32-bit word per cycle, accumulates the
// ones'-complement checksum over all header words (checksum field included)
// and reports the verdict one cycle after the last header word.
// Payload words after the header are ignored until the next start.
//
// Ports:
//   clk       in   1  clock, rising edge
//   reset     in   1  synchronous active-high reset (priority over start)
//   d_in      in  32  header word, word0[31:28]=version, [27:24]=IHL
//   d_in_vld  in   1  d_in qualifier
//   start     in   1  new-packet pulse, precedes word0
//   chk_vld   out  1  one-cycle result strobe
//   chk_ok    out  1  sum == FFFF and no error flag
//   chk_sum   out 16  folded 16-bit sum
//   err_ver   out  1  version != 4
//   err_ihl   out  1  IHL < 5
//
// Configuration macro IP_V4_HDR_CHECK_IHL_EN:
//   defined   - header length taken from IHL (IHL < 5 -> 5 words, err_ihl)
//   undefined - header length fixed at 5 words, err_ihl held 0
// ---------------------------------------------------------------------------
module ip_v4_header_check
  import ip_v4_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        d_in_vld,
  input  logic        start,
  output logic        chk_vld,
  output logic        chk_ok,
  output logic [15:0] chk_sum,
  output logic        err_ver,
  output logic        err_ihl
);

  ip_v4_state_t state_r;
  logic [15:0]  acc_r;
  logic [3:0]   cnt_r;       // header words accepted so far
  logic [3:0]   len_r;       // header length captured from word0
  logic         ver_bad_r;
  logic         ihl_bad_r;

  ip_v4_word_t  word_s;
  logic [15:0]  acc_next_s;
  logic [3:0]   word0_len_s;
  logic         word0_ihl_bad_s;
  logic         word0_ver_bad_s;
  logic [3:0]   len_s;
  logic         last_word_s;

  assign word_s = d_in;

  ip_v4_csum_add u_csum_add (
    .acc (acc_r),
    .hi  (word_s[31:16]),
    .lo  (word_s[15:0]),
    .sum (acc_next_s)
  );

  assign word0_ver_bad_s = (word_s[31:28] != IPV4_VERSION);

`ifdef IP_V4_HDR_CHECK_IHL_EN
  assign word0_ihl_bad_s = (word_s[27:24] < IHL_MIN);
  assign word0_len_s     = word0_ihl_bad_s ? IHL_MIN :
                           ((word_s[27:24] > IHL_MAX) ? IHL_MAX : word_s[27:24]);
`else
  assign word0_ihl_bad_s = 1'b0;
  assign word0_len_s     = IHL_MIN;
`endif

  // While word0 is being accepted len_r is stale, so use the live value.
  // Header length is at least 5, so word0 itself is never the last word.
  assign len_s       = (cnt_r == 4'd0) ? word0_len_s : len_r;
  assign last_word_s = (cnt_r == (len_s - 4'd1));

  // Packet FSM with accumulator, word counter and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      acc_r     <= 16'h0000;
      cnt_r     <= 4'd0;
      len_r     <= IHL_MIN;
      ver_bad_r <= 1'b0;
      ihl_bad_r <= 1'b0;
      chk_vld   <= 1'b0;
      chk_ok    <= 1'b0;
      chk_sum   <= 16'h0000;
      err_ver   <= 1'b0;
      err_ihl   <= 1'b0;
    end else begin
      chk_vld <= 1'b0;
      if (start) begin
        // Any state, including mid-header: the old packet is dropped silently.
        state_r <= ACC;
        acc_r   <= 16'h0000;
        cnt_r   <= 4'd0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          ACC: begin
            if (d_in_vld) begin
              acc_r <= acc_next_s;
              cnt_r <= cnt_r + 4'd1;
              if (cnt_r == 4'd0) begin
                len_r     <= word0_len_s;
                ver_bad_r <= word0_ver_bad_s;
                ihl_bad_r <= word0_ihl_bad_s;
              end else begin
                len_r     <= len_r;
              end
              if (last_word_s) begin
                state_r <= DONE;
                chk_vld <= 1'b1;
                chk_sum <= acc_next_s;
                chk_ok  <= (acc_next_s == 16'hFFFF) && !ver_bad_r && !ihl_bad_r;
                err_ver <= ver_bad_r;
                err_ihl <= ihl_bad_r;
              end else begin
                state_r <= ACC;
              end
            end else begin
              state_r <= ACC;
            end
          end
          DONE: begin
            state_r <= SKIP;
          end
          SKIP: begin
            state_r <= SKIP;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
